mem_except_unit: RTL
====================

Name: mem_except_unit

Overview:
- MEM-stage exception arbiter that sits directly upstream of the CP0 register file.
- Merges the per-instruction exception flags carried down the pipeline with data-address alignment checks and the pending interrupt condition.
- Resolves these by fixed priority into the single 32-bit exception code, EPC source address, delay-slot bit and BadVAddr that CP0 samples on the next clock edge.
- Generates the pipeline flush and redirect PC, then holds flush for a programmable number of cycles through a small state machine.

Parameters:
- EXC_VECTOR, 32'h0000_0020, handler entry PC for all exceptions except eret.
- FLUSH_CYCLES, 1, cycles flush_o stays high after the trigger cycle (1..15).
- ADEL_CODE, 32'h0000_0004, code emitted for load or fetch address error.
- ADES_CODE, 32'h0000_0005, code emitted for store address error.

Ports:
- clk  in  1  clock
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- inst_valid_i  in  1  MEM holds a real instruction (0 = bubble)
- pc_i  in  32  MEM instruction address
- in_delayslot_i  in  1  MEM instruction is in a branch delay slot
- except_flags_i  in  6  [0] syscall, [1] break, [2] reserved instr, [3] trap, [4] overflow, [5] eret
- mem_re_i / mem_we_i  in  1 each  load / store
- mem_size_i  in  2  0 = byte, 1 = half, 2 = word
- mem_addr_i  in  32  data address
- cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  current CP0 values
- wb_cp0_we_i  in  1  pending CP0 write in WB
- wb_cp0_waddr_i  in  5  target register of that write
- wb_cp0_data_i  in  32  data of that write
- excepttype_o  out  32  code to CP0
- current_inst_addr_o  out  32  pc_i passthrough
- is_in_delayslot_o  out  1  passthrough
- badvaddr_o  out  32  faulting address
- mem_suppress_o  out  1  kill this instruction's memory access
- flush_o  out  1  flush IF..MEM
- new_pc_o  out  32  redirect target
- busy_o  out  1  state != IDLE

Behaviour:
- CP0 forwarding (combinational):
  - status_eff = wb_data if a WB write targets Status (reg 12), else cp0_status_i.
  - epc_eff is formed the same way for EPC (reg 14).
  - cause_eff takes cp0_cause_i with bits 9:8, 22, 23 replaced by wb_data when a WB write targets Cause (reg 13).
- Interrupt condition: inst_valid_i & status_eff[0] & ~status_eff[1] & |(cause_eff[15:8] & status_eff[15:8]).
- Alignment checks:
  - fetch_adel = (pc_i[1:0] != 0).
  - data misaligned = (half & addr[0]) | (word & addr[1:0] != 0).
  - A misaligned load gives AdEL; a misaligned store gives AdES; byte accesses never fault.
- Priority, evaluated only when state == IDLE and inst_valid_i = 1; first match wins:
  1. interrupt -> 0x1
  2. fetch_adel -> ADEL_CODE, badvaddr_o = pc_i
  3. reserved instr -> 0xa
  4. syscall -> 0x8
  5. break -> 0x9
  6. overflow -> 0xc
  7. trap -> 0xd
  8. data AdEL -> ADEL_CODE, badvaddr_o = mem_addr_i
  9. data AdES -> ADES_CODE, badvaddr_o = mem_addr_i
  10. eret -> 0xe
  11. none -> 0
- Any nonzero code is a "take":
  - excepttype_o, flush_o and mem_suppress_o are asserted in the same cycle (combinational); CP0 latches on that edge.
  - new_pc_o = epc_eff for eret, EXC_VECTOR otherwise.
  - badvaddr_o = 0 when the code is not an address error.
- FSM:
  - IDLE --take--> FLUSH, with counter loaded to FLUSH_CYCLES.
  - In FLUSH: flush_o = 1, excepttype_o = 0, mem_suppress_o = 1, new_pc_o holds the registered target.
  - The counter decrements each cycle; FLUSH -> IDLE when the counter reaches 1.
  - No new exception is taken in FLUSH, even if inputs show flags; an interrupt still asserted is taken in the first valid IDLE cycle afterwards.
- Bubbles (inst_valid_i = 0) never take anything; outputs are 0 except the passthroughs.
- Reset: state IDLE, counter 0, registered target 0. While rst = 1, every output is 0, including the passthroughs. Reset mid-FLUSH returns to IDLE on the next edge.
- Simultaneous WB CP0 write and take: forwarded values are used, so a WB write clearing IE in the same cycle blocks the interrupt.

Test Plan:
- Status = 0x0000_0401, cause[10] = 1, valid instr at pc 0x100 -> excepttype_o = 0x1, flush_o = 1, new_pc_o = 0x20; flush_o is high for 2 cycles total.
- Load word at 0x1002 together with overflow flag -> excepttype_o = 0xc (overflow beats AdEL), badvaddr_o = 0.
- Store half at 0x2001 -> ADES_CODE, badvaddr_o = 0x2001, mem_suppress_o = 1.
- Eret with cp0_epc_i = 0x40 while WB writes EPC = 0x80 -> excepttype_o = 0xe, new_pc_o = 0x80.
- Syscall at pc 0x200 followed next cycle by break at 0x204 -> only 0x8 is reported; 0x204 is squashed during FLUSH (excepttype_o = 0).
- Interrupt asserted, WB writes Status = 0 in the same cycle -> no take; assert rst during FLUSH -> all outputs 0, busy_o = 0 after the edge.

Source files
------------

// File: rtl/mem_except_if.sv
// MEM-stage exception arbiter bus: pipeline/CP0 inputs and redirect/report outputs.
interface mem_except_if;
  logic        inst_valid_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic [5:0]  except_flags_i;
  logic        mem_re_i;
  logic        mem_we_i;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_addr_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic [31:0] badvaddr_o;
  logic        mem_suppress_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        busy_o;

  modport slave (
    input  inst_valid_i, pc_i, in_delayslot_i, except_flags_i,
           mem_re_i, mem_we_i, mem_size_i, mem_addr_i,
           cp0_status_i, cp0_cause_i, cp0_epc_i,
           wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    output excepttype_o, current_inst_addr_o, is_in_delayslot_o, badvaddr_o,
           mem_suppress_o, flush_o, new_pc_o, busy_o
  );

  modport master (
    output inst_valid_i, pc_i, in_delayslot_i, except_flags_i,
           mem_re_i, mem_we_i, mem_size_i, mem_addr_i,
           cp0_status_i, cp0_cause_i, cp0_epc_i,
           wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    input  excepttype_o, current_inst_addr_o, is_in_delayslot_o, badvaddr_o,
           mem_suppress_o, flush_o, new_pc_o, busy_o
  );
endinterface

// File: rtl/mem_except_unit.sv
// MEM-stage exception arbiter: forwards pending WB CP0 writes, checks alignment and
// interrupts, picks one exception by fixed priority, and holds flush for a few cycles.
module mem_except_unit #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter logic [31:0] ADEL_CODE    = 32'h0000_0004,
  parameter logic [31:0] ADES_CODE    = 32'h0000_0005
) (
  input  logic         clk,
  input  logic         rst,
  mem_except_if.slave  bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  logic [0:0]  state;
  logic [3:0]  cnt;
  logic [31:0] target_q;

  logic [31:0] status_eff;
  logic [31:0] cause_eff;
  logic [31:0] epc_eff;
  logic        int_pend;
  logic        fetch_adel;
  logic        data_mis;
  logic [31:0] code;
  logic [31:0] badv;
  logic        is_eret;
  logic        take;
  logic [31:0] take_pc;

  // Forward a CP0 write still sitting in WB so decisions see the newest Status/Cause/EPC.
  always_comb begin
    status_eff = bus.cp0_status_i;
    cause_eff  = bus.cp0_cause_i;
    epc_eff    = bus.cp0_epc_i;
    if (bus.wb_cp0_we_i) begin
      if (bus.wb_cp0_waddr_i == 5'd12) status_eff = bus.wb_cp0_data_i;
      if (bus.wb_cp0_waddr_i == 5'd14) epc_eff    = bus.wb_cp0_data_i;
      if (bus.wb_cp0_waddr_i == 5'd13) begin
        // Only the software-writable Cause fields are replaced.
        cause_eff[9:8]   = bus.wb_cp0_data_i[9:8];
        cause_eff[23:22] = bus.wb_cp0_data_i[23:22];
      end
    end
  end

  // Fixed-priority resolution of all exception sources into one code.
  always_comb begin
    int_pend   = bus.inst_valid_i & status_eff[0] & ~status_eff[1] &
                 (|(cause_eff[15:8] & status_eff[15:8]));
    fetch_adel = (bus.pc_i[1:0] != 2'b00);
    data_mis   = ((bus.mem_size_i == 2'd1) & bus.mem_addr_i[0]) |
                 ((bus.mem_size_i == 2'd2) & (bus.mem_addr_i[1:0] != 2'b00));
    code    = 32'h0;
    badv    = 32'h0;
    is_eret = 1'b0;
    if (state == IDLE && bus.inst_valid_i) begin
      if (int_pend)                        code = 32'h1;
      else if (fetch_adel) begin           code = ADEL_CODE; badv = bus.pc_i; end
      else if (bus.except_flags_i[2])      code = 32'ha;
      else if (bus.except_flags_i[0])      code = 32'h8;
      else if (bus.except_flags_i[1])      code = 32'h9;
      else if (bus.except_flags_i[4])      code = 32'hc;
      else if (bus.except_flags_i[3])      code = 32'hd;
      else if (bus.mem_re_i && data_mis) begin code = ADEL_CODE; badv = bus.mem_addr_i; end
      else if (bus.mem_we_i && data_mis) begin code = ADES_CODE; badv = bus.mem_addr_i; end
      else if (bus.except_flags_i[5]) begin code = 32'he; is_eret = 1'b1; end
    end
    take    = (code != 32'h0);
    take_pc = is_eret ? epc_eff : EXC_VECTOR;
  end

  // Drive outputs; everything is forced low while reset is held.
  always_comb begin
    bus.excepttype_o        = 32'h0;
    bus.current_inst_addr_o = 32'h0;
    bus.is_in_delayslot_o   = 1'b0;
    bus.badvaddr_o          = 32'h0;
    bus.mem_suppress_o      = 1'b0;
    bus.flush_o             = 1'b0;
    bus.new_pc_o            = 32'h0;
    bus.busy_o              = 1'b0;
    if (!rst) begin
      bus.current_inst_addr_o = bus.pc_i;
      bus.is_in_delayslot_o   = bus.in_delayslot_i;
      bus.busy_o              = (state != IDLE);
      if (state == FLUSH) begin
        bus.flush_o        = 1'b1;
        bus.mem_suppress_o = 1'b1;
        bus.new_pc_o       = target_q;
      end else if (take) begin
        bus.excepttype_o   = code;
        bus.badvaddr_o     = badv;
        bus.flush_o        = 1'b1;
        bus.mem_suppress_o = 1'b1;
        bus.new_pc_o       = take_pc;
      end
    end
  end

  // Flush-hold state machine: a take opens a window of FLUSH_CYCLES flush cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      target_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            state    <= FLUSH;
            cnt      <= FLUSH_LOAD;
            target_q <= take_pc;
          end
        end
        FLUSH: begin
          if (cnt <= 4'd1) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule
